// File: rtl/lfsr_pkg.sv
// Shared opcode, sequencer state and instruction-format definitions for the
// LFSR program sequencer and its datapath.
package lfsr_pkg;

    localparam int INSTR_W = 14;

    typedef enum logic [5:0] {
        NONE      = 6'h00,
        CFG_TAP   = 6'h01,
        INIT_L    = 6'h02,
        RUN       = 6'h03,
        STORE     = 6'h04,
        LOAD      = 6'h05,
        INIT_ADDR = 6'h06,
        ADD_ADDR  = 6'h07,
        STORE_HD  = 6'h09,
        AVG_HD    = 6'h0A,
        HALT      = 6'h3F
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_ISSUE,
        S_RUN,
        S_HALTED,
        S_ERROR
    } seq_state_e;

    // CFG_TAP uses shamt as a reserved bit, so a set shamt makes it undefined.
    function automatic logic is_legal(op_e op, logic shamt);
        case (op)
            CFG_TAP:  return !shamt;
            INIT_L, RUN, STORE, LOAD, INIT_ADDR,
            ADD_ADDR, STORE_HD, AVG_HD, HALT:
                      return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [6:0] run_steps(logic [6:0] funct);
        return (funct == 7'd0) ? 7'd1 : funct;
    endfunction

endpackage

// File: rtl/lfsr_prog_sequencer_if.sv
// Instruction-ROM and datapath command bus between the sequencer (master)
// and the ROM/LFSR datapath (slave).
interface lfsr_prog_sequencer_if;
    import lfsr_pkg::*;

    logic [7:0]         imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               dp_valid;
    logic               dp_ready;
    op_e                dp_op;
    logic [7:0]         dp_imm;

    modport master (
        output imem_addr, dp_valid, dp_op, dp_imm,
        input  imem_rdata, dp_ready
    );

    modport slave (
        input  imem_addr, dp_valid, dp_op, dp_imm,
        output imem_rdata, dp_ready
    );

endinterface

// File: rtl/lfsr_run_ctr.sv
// Loadable 7-bit down-counter holding the RUN steps still to issue; o_last
// flags the final step so the sequencer can advance on that handshake.
module lfsr_run_ctr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [6:0] i_load_val,
    input  logic       i_dec,
    output logic [6:0] o_count,
    output logic       o_last
);

    logic [6:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 7'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 7'd0)) begin
            r_count <= r_count - 7'd1;
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == 7'd1);

endmodule

// File: rtl/lfsr_prog_sequencer.sv
// Program sequencer: fetches and decodes 14-bit instructions from a synchronous
// ROM and issues one valid/ready command per instruction (or per RUN step).
module lfsr_prog_sequencer
    import lfsr_pkg::*;
#(
    parameter logic [7:0] START_ADDR = 8'h00,
    parameter int         IMEM_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    lfsr_prog_sequencer_if.master bus,
    output logic                  busy,
    output logic                  halted,
    output logic                  illegal,
    output logic [7:0]            pc,
    output logic [6:0]            run_left
);

    seq_state_e         r_state;
    seq_state_e         w_state_nxt;
    logic [7:0]         r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic               r_halted;
    logic               r_illegal;
    logic               r_rst_done;

    op_e                w_dec_op;
    logic               w_dec_shamt;
    logic [6:0]         w_dec_funct;
    logic               w_start_ok;
    logic               w_hs;
    logic               w_pc_inc;
    logic               w_pc_reload;
    logic               w_ir_load;
    logic               w_set_halt;
    logic               w_set_ill;
    logic               w_run_load;
    logic               w_run_dec;
    logic               w_run_last;
    logic [6:0]         w_run_cnt;

    assign w_dec_op    = op_e'(bus.imem_rdata[13:8]);
    assign w_dec_shamt = bus.imem_rdata[7];
    assign w_dec_funct = bus.imem_rdata[6:0];

    // r_rst_done blocks a start that coincides with the first edge after reset.
    assign w_start_ok = start && r_rst_done;
    assign w_hs       = bus.dp_valid && bus.dp_ready;

    lfsr_run_ctr u_run_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_run_load),
        .i_load_val (run_steps(w_dec_funct)),
        .i_dec      (w_run_dec),
        .o_count    (w_run_cnt),
        .o_last     (w_run_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= START_ADDR;
            r_ir       <= '0;
            r_halted   <= 1'b0;
            r_illegal  <= 1'b0;
            r_rst_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rst_done <= 1'b1;
            if (w_pc_reload) begin
                r_pc <= START_ADDR;
            end else if (w_pc_inc) begin
                r_pc <= r_pc + 8'd1;
            end
            if (w_ir_load) begin
                r_ir <= bus.imem_rdata;
            end
            if (w_pc_reload) begin
                r_halted  <= 1'b0;
                r_illegal <= 1'b0;
            end
            if (w_set_halt) begin
                r_halted <= 1'b1;
            end
            if (w_set_ill) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_inc    = 1'b0;
        w_pc_reload = 1'b0;
        w_ir_load   = 1'b0;
        w_set_halt  = 1'b0;
        w_set_ill   = 1'b0;
        w_run_load  = 1'b0;
        w_run_dec   = 1'b0;
        case (r_state)
            S_IDLE, S_HALTED, S_ERROR: begin
                if (w_start_ok) begin
                    w_state_nxt = S_FETCH;
                    w_pc_reload = 1'b1;
                end
            end
            S_FETCH: begin
                w_state_nxt = (IMEM_LAT == 1) ? S_DECODE : S_WAIT;
            end
            S_WAIT: begin
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                w_ir_load = 1'b1;
                if (!is_legal(w_dec_op, w_dec_shamt)) begin
                    w_state_nxt = S_ERROR;
                    w_set_ill   = 1'b1;
                end else if (w_dec_op == HALT) begin
                    w_state_nxt = S_HALTED;
                    w_set_halt  = 1'b1;
                end else if (w_dec_op == RUN) begin
                    w_state_nxt = S_RUN;
                    w_run_load  = 1'b1;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_hs) begin
                    w_state_nxt = S_FETCH;
                    w_pc_inc    = 1'b1;
                end
            end
            S_RUN: begin
                if (w_hs) begin
                    w_run_dec = 1'b1;
                    if (w_run_last) begin
                        w_state_nxt = S_FETCH;
                        w_pc_inc    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Command outputs come straight from state and the instruction register so
    // they drop with an asynchronous reset and stay frozen while stalled.
    always_comb begin
        bus.dp_valid = (r_state == S_ISSUE) || (r_state == S_RUN);
        bus.dp_op    = NONE;
        bus.dp_imm   = 8'h00;
        if (bus.dp_valid) begin
            bus.dp_op  = op_e'(r_ir[13:8]);
            bus.dp_imm = r_ir[7:0];
        end
    end

    assign bus.imem_addr = r_pc;
    assign pc            = r_pc;
    assign halted        = r_halted;
    assign illegal       = r_illegal;
    assign run_left      = w_run_cnt;
    assign busy          = (r_state != S_IDLE) && (r_state != S_HALTED) && (r_state != S_ERROR);

endmodule
